shift_deserializer: RTL and testbench
=====================================

# shift_deserializer

Serial-to-parallel receiver for the lab shift-register datapath. It captures a word that an upstream right-shifting register emits LSB-first, one bit per qualified clock. It presents the assembled word with a valid/acknowledge handshake. It sits between the serial output of a shifter chain and the LEDR/display logic, or a downstream register.

## Interface
- WIDTH, 8, word length in bits (≥2)
- CW, $clog2(WIDTH+1), bit-counter width
- clock  in  1  rising-edge system clock
- reset_n  in  1  asynchronous active-low reset; clears all state immediately
- start  in  1  one-cycle strobe that begins a new frame
- serial_in  in  1  serial data bit, LSB of the word first
- bit_valid  in  1  serial_in is sampled on each rising edge where this is high
- data_ack  in  1  consumer accepts data_out
- data_out  out  WIDTH  last completed word (registered)
- data_valid  out  1  data_out holds an unacknowledged word
- busy  out  1  high while a frame is being received
- overrun  out  1  sticky: start arrived while a word was still unacknowledged

## Operation
- State machine, states IDLE, RECV, HOLD. Reset state is IDLE.
- Reset values: data_out=0, data_valid=0, busy=0, overrun=0, bit counter=0, shift register=0.
- IDLE:
  - start → RECV with counter cleared.
  - bit_valid, serial_in and data_ack are ignored.
- RECV:
  - Each edge with bit_valid=1 does shreg <= {serial_in, shreg[WIDTH-1:1]} and counter += 1.
  - Cycles with bit_valid=0 hold all state; gaps of any length are legal.
  - On the edge that captures bit WIDTH-1 (counter==WIDTH-1 and bit_valid=1):
    - data_out <= {serial_in, shreg[WIDTH-1:1]}
    - data_valid <= 1
    - state → HOLD
    - counter → 0
  - start during RECV aborts the partial frame. The counter is cleared, state stays RECV, and serial_in on the start cycle is not captured. data_out is unchanged.
- HOLD:
  - data_ack=1 → data_valid <= 0, overrun <= 0, state → IDLE.
  - start without data_ack → overrun <= 1; start is otherwise ignored and state stays HOLD.
  - start and data_ack in the same cycle → data_valid <= 0, overrun <= 0, state → RECV (no overrun).
  - bit_valid in HOLD is ignored; those bits are lost.
- start has priority over bit_valid in every state.
- busy = (state==RECV), decoded from registered state.
- data_out changes only on frame completion.

## Timing
- All outputs are registered, or decoded from registered state only. There are no combinational paths from inputs to outputs.
- busy rises on the edge that samples start.
- First bit sampled: the first bit_valid edge strictly after the start edge.
- Latency: data_valid rises on the same edge that samples the WIDTH-th bit. Minimum start-to-data_valid is WIDTH+1 edges when bit_valid is held high.
- data_valid falls on the edge that samples data_ack; the next frame can begin on that same edge.
- Back-to-back throughput: one word per WIDTH+1 cycles when the consumer acks during the HOLD cycle together with start.
- Asynchronous reset mid-frame:
  - Outputs return to their reset values without a clock edge.
  - The partial word is discarded.
  - After release, the block waits in IDLE for start.

## Test plan
- Reset: assert reset_n=0 between edges → data_out=0x00, data_valid=0, busy=0, overrun=0 immediately.
- Basic frame:
  - Stimulus: start, then bit_valid=1 for 8 cycles with serial_in 1,0,1,0,0,1,0,1.
  - Response: data_out=0xA5 and data_valid=1 on the 8th bit edge, busy=0.
  - Then data_ack → data_valid=0 one edge later.
- Gapped bits: the 0x3C bit sequence with bit_valid low for 3 cycles between bits 2/3 and 5/6 → data_out=0x3C. No early data_valid.
- Restart:
  - Stimulus: start, 5 bits of 0xFF, start again, then 8 bits of 0x81.
  - Response: data_out=0x81; data_valid asserts only once.
- Overrun and combined handshake:
  - Complete 0x5A and leave it unacked, then pulse start alone → overrun=1, state still HOLD, data_out=0x5A.
  - Pulse start+data_ack together → overrun=0, data_valid=0, busy=1.
  - Then 8 bits of 0x0F → data_out=0x0F.
- Reset mid-frame: after 4 bits, pulse reset_n low → all outputs 0. Bits then fed without start → no data_valid. A full frame after start completes correctly.

Source files
------------

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver. Assembles an LSB-first word from a
// right-shifting upstream register, one bit per bit_valid edge, and
// presents it with a valid/acknowledge handshake.
module shift_deserializer #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;

    // Next shift value: new bit enters at the MSB so the first bit ends at the LSB
    assign shreg_nxt = {serial_in, shreg[WIDTH-1:1]};

    // busy is a pure decode of the registered state
    assign busy = (state == RECV);

    // Frame sequencing, bit capture and handshake; start wins over bit_valid
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RECV;
                        bit_cnt <= '0;
                    end
                end
                RECV: begin
                    if (start) begin
                        // Abort the partial frame; the stale shreg contents are
                        // fully shifted out by the next WIDTH bits.
                        bit_cnt <= '0;
                    end else if (bit_valid) begin
                        shreg <= shreg_nxt;
                        if (bit_cnt == CW'(WIDTH - 1)) begin
                            data_out   <= shreg_nxt;
                            data_valid <= 1'b1;
                            state      <= HOLD;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (data_ack) begin
                        data_valid <= 1'b0;
                        overrun    <= 1'b0;
                        bit_cnt    <= '0;
                        state      <= start ? RECV : IDLE;
                    end else if (start) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer with hand-computed expectations.
module tb_shift_deserializer;

    localparam int WIDTH = 8;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             serial_in;
    logic             bit_valid;
    logic             data_ack;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             overrun;

    int checks   = 0;
    int failures = 0;

    shift_deserializer #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .data_ack   (data_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Sends bits 0..n-1 of w LSB first
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[i]);
    endtask

    task automatic ack();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b1;
        start     = 1'b0;
        serial_in = 1'b0;
        bit_valid = 1'b0;
        data_ack  = 1'b0;

        // Reset asserted between edges takes effect immediately
        #1 reset_n = 1'b0;
        #1;
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        #1 reset_n = 1'b1;
        tick();

        // Inputs other than start ignored in IDLE
        data_ack = 1'b1;
        send_bit(1'b1);
        data_ack = 1'b0;
        chk("idle_ignore_busy", 32'(busy), 0);

        // Basic frame 0xA5
        pulse_start();
        chk("basic_busy_rise", 32'(busy), 1);
        send_bits(8'hA5, 7);
        chk("basic_no_early_valid", 32'(data_valid), 0);
        send_bit(1'b1);
        chk("basic_data", 32'(data_out), 32'hA5);
        chk("basic_valid", 32'(data_valid), 1);
        chk("basic_busy_fall", 32'(busy), 0);
        ack();
        chk("basic_ack_valid", 32'(data_valid), 0);
        chk("basic_ack_busy", 32'(busy), 0);

        // Gapped bits 0x3C
        pulse_start();
        send_bits(8'h3C, 3);
        idle(3);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        idle(3);
        chk("gap_no_early_valid", 32'(data_valid), 0);
        chk("gap_busy_hold", 32'(busy), 1);
        send_bit(1'b0);
        chk("gap_no_early_valid7", 32'(data_valid), 0);
        send_bit(1'b0);
        chk("gap_data", 32'(data_out), 32'h3C);
        chk("gap_valid", 32'(data_valid), 1);
        ack();

        // Restart mid-frame, then 0x81
        pulse_start();
        send_bits(8'hFF, 5);
        serial_in = 1'b1;
        bit_valid = 1'b1;
        pulse_start();          // bit on the start cycle must not be captured
        bit_valid = 1'b0;
        send_bits(8'h81, 7);
        chk("restart_no_early_valid", 32'(data_valid), 0);
        chk("restart_data_unchanged", 32'(data_out), 32'h3C);
        send_bit(1'b1);
        chk("restart_data", 32'(data_out), 32'h81);
        chk("restart_valid", 32'(data_valid), 1);
        ack();

        // Overrun, then combined start+ack
        pulse_start();
        send_bits(8'h5A, 8);
        chk("ovr_valid", 32'(data_valid), 1);
        send_bit(1'b1);         // lost while in HOLD
        pulse_start();
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_busy", 32'(busy), 0);
        chk("ovr_data", 32'(data_out), 32'h5A);
        chk("ovr_valid_kept", 32'(data_valid), 1);
        idle(2);
        chk("ovr_sticky", 32'(overrun), 1);
        start    = 1'b1;
        data_ack = 1'b1;
        tick();
        start    = 1'b0;
        data_ack = 1'b0;
        chk("comb_overrun", 32'(overrun), 0);
        chk("comb_valid", 32'(data_valid), 0);
        chk("comb_busy", 32'(busy), 1);
        send_bits(8'h0F, 8);
        chk("comb_data", 32'(data_out), 32'h0F);
        chk("comb_valid2", 32'(data_valid), 1);
        ack();

        // Asynchronous reset mid-frame
        pulse_start();
        send_bits(8'hFF, 4);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_data", 32'(data_out), 32'h00);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(data_valid), 0);
        #1 reset_n = 1'b1;
        tick();
        send_bits(8'hFF, 8);
        chk("post_rst_no_valid", 32'(data_valid), 0);
        chk("post_rst_idle", 32'(busy), 0);
        pulse_start();
        send_bits(8'hC3, 8);
        chk("post_rst_data", 32'(data_out), 32'hC3);
        chk("post_rst_valid", 32'(data_valid), 1);
        ack();
        chk("post_rst_ack", 32'(data_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
